// File: rtl/parallel_adder_pkg.sv
// rtl/parallel_adder_pkg.sv - shared width, types and reference helper for the 4-bit adder
package parallel_adder_pkg;

    localparam int ADDER_W = 4;

    typedef logic [ADDER_W-1:0] nibble_t;

    // Carry-out and sum kept together so the output register moves as one word
    typedef struct packed {
        logic    cout;
        nibble_t sum;
    } adder_result_t;

    localparam adder_result_t ADDER_RESULT_ZERO = '{cout: 1'b0, sum: '0};

    // Packs a carry/sum pair into the registered result word
    function automatic adder_result_t pack_result(input logic cout, input nibble_t sum);
        adder_result_t r;
        r.cout = cout;
        r.sum  = sum;
        return r;
    endfunction

endpackage

// File: rtl/parallel_adder_4bit_full_adder.sv
// rtl/parallel_adder_4bit_full_adder.sv - single-bit full adder cell of the ripple chain
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum is the three-way parity; carry is the majority of the three inputs
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end

endmodule

// File: rtl/parallel_adder_4bit.sv
// rtl/parallel_adder_4bit.sv - 4-bit ripple-carry adder with combinational and registered results
module parallel_adder_4bit
    import parallel_adder_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDER_W-1:0] A,
    input  logic [ADDER_W-1:0] B,
    input  logic               Cin,
    output logic [ADDER_W-1:0] Sum,
    output logic               Cout,
    output logic [ADDER_W-1:0] Sum_q,
    output logic               Cout_q
);

    // carry[i] feeds bit i; carry[ADDER_W] is the final carry-out
    logic [ADDER_W:0]   carry;
    nibble_t            sum_bits;
    adder_result_t      result_d;
    adder_result_t      result_q;

    assign carry[0] = Cin;

    // One full-adder cell per bit, chained through the carry vector
    for (genvar i = 0; i < ADDER_W; i++) begin : g_ripple
        full_adder u_full_adder (
            .a  (A[i]),
            .b  (B[i]),
            .ci (carry[i]),
            .s  (sum_bits[i]),
            .co (carry[i+1])
        );
    end

    // Combinational outputs track the inputs regardless of clock or reset
    always_comb begin
        Sum      = sum_bits;
        Cout     = carry[ADDER_W];
        result_d = pack_result(carry[ADDER_W], sum_bits);
    end

    // Registered copy: cleared immediately by rst, otherwise captured every edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= ADDER_RESULT_ZERO;
        end else begin
            result_q <= result_d;
        end
    end

    assign Sum_q  = result_q.sum;
    assign Cout_q = result_q.cout;

endmodule

// File: tb/tb_parallel_adder_4bit.sv
// tb/tb_parallel_adder_4bit.sv - directed self-checking bench for parallel_adder_4bit
`timescale 1ns/1ps
module tb_parallel_adder_4bit;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic [3:0] Sum;
    logic       Cout;
    logic [3:0] Sum_q;
    logic       Cout_q;

    int checks;
    int errors;

    parallel_adder_4bit dut (
        .clk    (clk),
        .rst    (rst),
        .A      (A),
        .B      (B),
        .Cin    (Cin),
        .Sum    (Sum),
        .Cout   (Cout),
        .Sum_q  (Sum_q),
        .Cout_q (Cout_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; A = 4'd0; B = 4'd0; Cin = 1'b0;
        #1;
        checks++;
        if ({Cout_q, Sum_q} !== 5'b0_0000) begin
            errors++; $display("FAIL reset_regs: got %b expected 00000", {Cout_q, Sum_q});
        end
        A = 4'd3; B = 4'd4; Cin = 1'b0;
        #1;
        checks++;
        if ({Cout, Sum} !== 5'b0_0111) begin
            errors++; $display("FAIL reset_comb_live: got %b expected 00111", {Cout, Sum});
        end
        @(posedge clk); #1;
        checks++;
        if ({Cout_q, Sum_q} !== 5'b0_0000) begin
            errors++; $display("FAIL reset_hold_over_edge: got %b expected 00000", {Cout_q, Sum_q});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_exhaustive();
        logic [4:0] expv;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    A = 4'(a); B = 4'(b); Cin = 1'(c);
                    expv = 5'(a + b + c);
                    #1;
                    checks++;
                    if ({Cout, Sum} !== expv) begin
                        errors++;
                        $display("FAIL sweep a=%0d b=%0d cin=%0d: got %b expected %b", a, b, c, {Cout, Sum}, expv);
                    end
                end
            end
        end
    endtask

    task automatic test_sample_points();
        A = 4'b0101; B = 4'b0011; Cin = 1'b0;
        #1;
        checks++;
        if (Sum !== 4'b1000 || Cout !== 1'b0) begin
            errors++; $display("FAIL sample_5_3_0: got Sum=%b Cout=%b expected Sum=1000 Cout=0", Sum, Cout);
        end
        A = 4'b1111; B = 4'b1111; Cin = 1'b1;
        #1;
        checks++;
        if (Sum !== 4'b1111 || Cout !== 1'b1) begin
            errors++; $display("FAIL sample_max: got Sum=%b Cout=%b expected Sum=1111 Cout=1", Sum, Cout);
        end
        A = 4'b0000; B = 4'b0000; Cin = 1'b0;
        #1;
        checks++;
        if (Sum !== 4'b0000 || Cout !== 1'b0) begin
            errors++; $display("FAIL sample_zero: got Sum=%b Cout=%b expected Sum=0000 Cout=0", Sum, Cout);
        end
    endtask

    task automatic test_carry_ripple();
        A = 4'b1111; B = 4'b0000; Cin = 1'b1;
        #1;
        checks++;
        if (Sum !== 4'b0000 || Cout !== 1'b1) begin
            errors++; $display("FAIL carry_ripple: got Sum=%b Cout=%b expected Sum=0000 Cout=1", Sum, Cout);
        end
        A = 4'b0000; B = 4'b1111; Cin = 1'b1;
        #1;
        checks++;
        if (Sum !== 4'b0000 || Cout !== 1'b1) begin
            errors++; $display("FAIL carry_ripple_b: got Sum=%b Cout=%b expected Sum=0000 Cout=1", Sum, Cout);
        end
    endtask

    task automatic test_registered();
        @(negedge clk);
        A = 4'b0001; B = 4'b0001; Cin = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({Cout_q, Sum_q} !== 5'b0_0010) begin
            errors++; $display("FAIL reg_preload: got %b expected 00010", {Cout_q, Sum_q});
        end
        @(negedge clk);
        A = 4'b1001; B = 4'b0111; Cin = 1'b0;
        #1;
        checks++;
        if ({Cout_q, Sum_q} !== 5'b0_0010) begin
            errors++; $display("FAIL reg_before_edge: got %b expected 00010", {Cout_q, Sum_q});
        end
        @(posedge clk); #1;
        checks++;
        if (Sum_q !== 4'b0000 || Cout_q !== 1'b1) begin
            errors++; $display("FAIL reg_after_edge: got Sum_q=%b Cout_q=%b expected Sum_q=0000 Cout_q=1", Sum_q, Cout_q);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] va [3];
        logic [3:0] vb [3];
        logic       vc [3];
        logic [4:0] ve [3];
        va[0] = 4'd7;  vb[0] = 4'd8;  vc[0] = 1'b0; ve[0] = 5'b0_1111;
        va[1] = 4'd8;  vb[1] = 4'd8;  vc[1] = 1'b0; ve[1] = 5'b1_0000;
        va[2] = 4'd12; vb[2] = 4'd6;  vc[2] = 1'b1; ve[2] = 5'b1_0011;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            A = va[i]; B = vb[i]; Cin = vc[i];
            @(posedge clk); #1;
            checks++;
            if ({Cout_q, Sum_q} !== ve[i]) begin
                errors++; $display("FAIL back_to_back[%0d]: got %b expected %b", i, {Cout_q, Sum_q}, ve[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        A = 4'b0101; B = 4'b0101; Cin = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (Sum_q !== 4'b1010 || Cout_q !== 1'b0) begin
            errors++; $display("FAIL async_preload: got Sum_q=%b Cout_q=%b expected Sum_q=1010 Cout_q=0", Sum_q, Cout_q);
        end
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if (Sum_q !== 4'b0000 || Cout_q !== 1'b0) begin
            errors++; $display("FAIL async_clear: got Sum_q=%b Cout_q=%b expected 0000/0", Sum_q, Cout_q);
        end
        checks++;
        if (Sum !== 4'b1010 || Cout !== 1'b0) begin
            errors++; $display("FAIL async_comb_live: got Sum=%b Cout=%b expected Sum=1010 Cout=0", Sum, Cout);
        end
        A = 4'b1100;
        #1;
        checks++;
        if (Sum !== 4'b0001 || Cout !== 1'b1) begin
            errors++; $display("FAIL async_comb_track: got Sum=%b Cout=%b expected Sum=0001 Cout=1", Sum, Cout);
        end
    endtask

    task automatic test_reset_release();
        A = 4'b0010; B = 4'b0011; Cin = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({Cout_q, Sum_q} !== 5'b0_0000) begin
            errors++; $display("FAIL release_before_edge: got %b expected 00000", {Cout_q, Sum_q});
        end
        @(posedge clk); #1;
        checks++;
        if (Sum_q !== 4'b0110 || Cout_q !== 1'b0) begin
            errors++; $display("FAIL release_first_capture: got Sum_q=%b Cout_q=%b expected Sum_q=0110 Cout_q=0", Sum_q, Cout_q);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_exhaustive();
        test_sample_points();
        test_carry_ripple();
        test_registered();
        test_back_to_back();
        test_async_reset();
        test_reset_release();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
